// File: rtl/audio_mixer_controller_n.sv
// Audio DMA/mixer controller: CPU register file, round-robin DMA arbiter, per-channel
// fetch engines and a 3-stage saturating stereo mixer. Optional IRQ: AUDIO_MIXER_IRQ_EN.
module AUDIO_channel (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        setup_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] count_i,
  input  logic        dma_ready_i,
  input  logic [31:0] dma_rdata_i,
  input  logic        sample_clk_i,
  output logic        dma_req_o,
  output logic [31:0] dma_addr_o,
  output logic        busy_o,
  output logic [31:0] sample_o
);
  logic [31:0] ptr_q, remain_q, buf_q, sample_q;
  logic        full_q;

  // One-word prefetch buffer; word layout is {right[15:0], left[15:0]}.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      remain_q <= '0;
      buf_q    <= '0;
      sample_q <= '0;
      full_q   <= 1'b0;
    end else if (setup_i) begin
      ptr_q    <= addr_i;
      remain_q <= count_i;
      full_q   <= 1'b0;
    end else begin
      if (sample_clk_i && full_q) begin
        sample_q <= buf_q;
        full_q   <= 1'b0;
      end
      if (dma_ready_i && dma_req_o) begin
        buf_q    <= dma_rdata_i;
        full_q   <= 1'b1;
        ptr_q    <= ptr_q + 32'd4;
        remain_q <= remain_q - 32'd1;
      end
    end
  end

  assign dma_req_o  = (remain_q != 32'd0) && !full_q;
  assign dma_addr_o = ptr_q;
  assign busy_o     = (remain_q != 32'd0) || full_q;
  assign sample_o   = sample_q;
endmodule

module audio_mixer_controller_n #(
  parameter int NUM_CHANNELS = 8,
  parameter int CLOCK_HZ     = 100_000_000,
  parameter int DEFAULT_RATE = 22050,
  parameter int VOLUME_BITS  = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [7:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_dma_request,
  output logic [31:0] o_dma_address,
  input  logic        i_dma_ready,
  input  logic [31:0] i_dma_rdata,
  input  logic        i_output_sample_clock,
  output logic [31:0] o_output_sample_rate,
  output logic [15:0] o_output_sample_left,
  output logic [15:0] o_output_sample_right
`ifdef AUDIO_MIXER_IRQ_EN
  , output logic      o_interrupt
`endif
);
  localparam int CW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int VB  = VOLUME_BITS;
  localparam int PW  = 16 + VB;
  localparam int PRW = PW + 1;
  localparam int SW  = 16 + VB + 4;
  localparam int MW  = SW + VB + 1;
  localparam logic [31:0]   RESET_DIV = 32'(CLOCK_HZ / (256 * DEFAULT_RATE));
  localparam logic [VB-1:0] UNITY     = {1'b1, {(VB-1){1'b0}}};
  localparam logic signed [MW-1:0] SAT_MAX = MW'(32767);
  localparam logic signed [MW-1:0] SAT_MIN = -MW'(32768);

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_e;

  logic                             ready_q;
  logic [31:0]                      rdata_q, rate_q, rd_val;
  logic [VB-1:0]                    master_q;
  logic [NUM_CHANNELS-1:0][31:0]    ch_addr_q, ch_count_q, ch_dma_addr, ch_sample;
  logic [NUM_CHANNELS-1:0][VB-1:0]  ch_vol_q;
  logic [NUM_CHANNELS-1:0]          done_q, busy_prev_q, setup_q, setup_d, w1c, ch_hit;
  logic [NUM_CHANNELS-1:0]          busy, ch_req, ch_ready;
  logic                             access, wr;
`ifdef AUDIO_MIXER_IRQ_EN
  logic [NUM_CHANNELS-1:0]          irq_en_q;
  logic                             irq_q;
`endif

  assign access = i_request && !ready_q;
  assign wr     = access && i_rw;

  always_comb begin
    rd_val  = '0;
    w1c     = '0;
    setup_d = '0;
    ch_hit  = '0;
    case (i_address)
      8'h00: rd_val = rate_q;
      8'h01: rd_val = 32'(busy);
      8'h02: rd_val = 32'(master_q);
      8'h03: rd_val = 32'(done_q);
`ifdef AUDIO_MIXER_IRQ_EN
      8'h04: rd_val = 32'(irq_en_q);
`endif
      default: ;
    endcase
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      ch_hit[n]  = (i_address[7:2] == 6'(n + 4));
      setup_d[n] = wr && ch_hit[n] && (i_address[1:0] == 2'd1);
      if (ch_hit[n]) begin
        case (i_address[1:0])
          2'd0:    rd_val = ch_addr_q[n];
          2'd1:    rd_val = ch_count_q[n];
          2'd2:    rd_val = 32'(ch_vol_q[n]);
          default: ;
        endcase
      end
    end
    if (wr && i_address == 8'h03) w1c = i_wdata[NUM_CHANNELS-1:0];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      rate_q      <= RESET_DIV;
      master_q    <= UNITY;
      ch_addr_q   <= '0;
      ch_count_q  <= '0;
      ch_vol_q    <= {NUM_CHANNELS{UNITY}};
      done_q      <= '0;
      busy_prev_q <= '0;
      setup_q     <= '0;
    end else begin
      // Holding i_request keeps o_ready high; access fires only on the 0->1 ready edge.
      ready_q     <= i_request;
      setup_q     <= setup_d;
      busy_prev_q <= busy;
      done_q      <= (done_q & ~w1c) | (busy_prev_q & ~busy);
      if (access) rdata_q <= rd_val;
      if (wr) begin
        case (i_address)
          8'h00:   rate_q   <= i_wdata;
          8'h02:   master_q <= i_wdata[VB-1:0];
          default: ;
        endcase
        for (int n = 0; n < NUM_CHANNELS; n++) begin
          if (ch_hit[n]) begin
            case (i_address[1:0])
              2'd0:    ch_addr_q[n]  <= i_wdata;
              2'd1:    ch_count_q[n] <= i_wdata;
              2'd2:    ch_vol_q[n]   <= i_wdata[VB-1:0];
              default: ;
            endcase
          end
        end
      end
    end
  end

`ifdef AUDIO_MIXER_IRQ_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && i_address == 8'h04) irq_en_q <= i_wdata[NUM_CHANNELS-1:0];
      irq_q <= |(done_q & irq_en_q);
    end
  end
  assign o_interrupt = irq_q;
`endif

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    AUDIO_channel u_ch (
      .clk_i        (i_clock),
      .rst_i        (i_reset),
      .setup_i      (setup_q[g]),
      .addr_i       (ch_addr_q[g]),
      .count_i      (ch_count_q[g]),
      .dma_ready_i  (ch_ready[g]),
      .dma_rdata_i  (i_dma_rdata),
      .sample_clk_i (i_output_sample_clock),
      .dma_req_o    (ch_req[g]),
      .dma_addr_o   (ch_dma_addr[g]),
      .busy_o       (busy[g]),
      .sample_o     (ch_sample[g])
    );
  end

  arb_e          state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d, grant_q, grant_d;
  logic [31:0]   addr_q, addr_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    int  idx;
    logic found;
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    found   = 1'b0;
    idx     = 0;
    case (state_q)
      ARB_IDLE: begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
          for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (!found && idx == n && ch_req[n]) begin
              found   = 1'b1;
              grant_d = CW'(n);
              addr_d  = ch_dma_addr[n];
              state_d = ARB_WAIT;
            end
          end
        end
      end
      ARB_WAIT: begin
        if (i_dma_ready) begin
          state_d = ARB_IDLE;
          ptr_d   = (grant_q == CW'(NUM_CHANNELS - 1)) ? '0 : grant_q + CW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_dma_request = (state_q == ARB_WAIT);
    ch_ready      = '0;
    for (int n = 0; n < NUM_CHANNELS; n++)
      ch_ready[n] = (state_q == ARB_WAIT) && i_dma_ready && (grant_q == CW'(n));
  end

  assign o_dma_address = addr_q;

  // Mixer: index [1:0] is side, 0 = left (low half of sample word), 1 = right.
  logic [NUM_CHANNELS-1:0][1:0][PW-1:0] s1_q, s1_d;
  logic [1:0][SW-1:0]                   sum_q, sum_d;
  logic [1:0][15:0]                     out_q, out_d;
  logic signed [PRW-1:0]                prod_c, sh_c;
  logic signed [MW-1:0]                 mprod_c, msh_c;

  always_comb begin
    prod_c  = '0;
    sh_c    = '0;
    mprod_c = '0;
    msh_c   = '0;
    s1_d    = '0;
    sum_d   = '0;
    out_d   = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      for (int s = 0; s < 2; s++) begin
        prod_c     = PRW'($signed(ch_sample[n][16*s +: 16])) * PRW'($signed({1'b0, ch_vol_q[n]}));
        sh_c       = prod_c >>> (VB - 1);
        s1_d[n][s] = sh_c[PW-1:0];
        sum_d[s]   = sum_d[s] + SW'($signed(s1_q[n][s]));
      end
    end
    for (int s = 0; s < 2; s++) begin
      mprod_c = MW'($signed(sum_q[s])) * MW'($signed({1'b0, master_q}));
      msh_c   = mprod_c >>> (VB - 1);
      if (msh_c > SAT_MAX)      out_d[s] = 16'h7FFF;
      else if (msh_c < SAT_MIN) out_d[s] = 16'h8000;
      else                      out_d[s] = msh_c[15:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1_q  <= '0;
      sum_q <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      sum_q <= sum_d;
      out_q <= out_d;
    end
  end

  assign o_rdata               = rdata_q;
  assign o_ready               = ready_q;
  assign o_output_sample_rate  = rate_q;
  assign o_output_sample_left  = out_q[0];
  assign o_output_sample_right = out_q[1];
endmodule

// File: tb/tb_audio_mixer_controller_n.sv
// Directed bench for audio_mixer_controller_n: register table, arbiter order,
// mixer latency/volume/saturation, done-flag W1C races, optional interrupt.
module tb_audio_mixer_controller_n;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_request = 1'b0, i_rw = 1'b0;
  logic [7:0]  i_address = '0;
  logic [31:0] i_wdata = '0, o_rdata;
  logic        o_ready, o_dma_request, i_dma_ready = 1'b0, i_output_sample_clock = 1'b0;
  logic [31:0] o_dma_address, i_dma_rdata = '0, o_output_sample_rate;
  logic [15:0] o_output_sample_left, o_output_sample_right;
`ifdef AUDIO_MIXER_IRQ_EN
  logic        o_interrupt;
`endif

  audio_mixer_controller_n dut (
    .i_clock(clk), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready),
    .o_dma_request(o_dma_request), .o_dma_address(o_dma_address),
    .i_dma_ready(i_dma_ready), .i_dma_rdata(i_dma_rdata),
    .i_output_sample_clock(i_output_sample_clock),
    .o_output_sample_rate(o_output_sample_rate),
    .o_output_sample_left(o_output_sample_left),
    .o_output_sample_right(o_output_sample_right)
`ifdef AUDIO_MIXER_IRQ_EN
    , .o_interrupt(o_interrupt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;

  typedef struct {
    logic [7:0]  vol;
    logic [7:0]  mvol;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } mix_vec_t;

  reg_vec_t rv[$];
  mix_vec_t mv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic cpu_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int n;
    i_request = 1'b1; i_rw = w; i_address = a; i_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ready && n < 20);
    if (!o_ready) timeout_fail("cpu_ready_rise");
    rd = o_rdata;
    i_request = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (o_ready && n < 20);
    if (o_ready) timeout_fail("cpu_ready_fall");
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    cpu_xfer(1'b1, a, d, dummy);
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
    cpu_xfer(1'b0, a, 32'h0, d);
  endtask

  task automatic wait_dma_req();
    int n = 0;
    while (!o_dma_request && n < 50) begin @(negedge clk); n++; end
    if (!o_dma_request) timeout_fail("dma_request");
  endtask

  // Answers one DMA request with i_dma_ready delayed 3 cycles.
  task automatic serve_dma(input logic [31:0] data, output logic [31:0] a);
    wait_dma_req();
    a = o_dma_address;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dma_addr_hold", o_dma_address, a);
    end
    check("dma_req_hold", 32'(o_dma_request), 32'd1);
    i_dma_ready = 1'b1; i_dma_rdata = data;
    @(negedge clk);
    i_dma_ready = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic [31:0] exp_irq_reg;
`ifdef AUDIO_MIXER_IRQ_EN
    exp_irq_reg = 32'h5;
`else
    exp_irq_reg = 32'h0;
`endif
    rv.push_back('{1'b1, 8'h00, 32'h55,       32'h0,        "w_rate"});
    rv.push_back('{1'b0, 8'h00, 32'h0,        32'h55,       "rate_rw"});
    rv.push_back('{1'b0, 8'h02, 32'h0,        32'h80,       "master_reset"});
    rv.push_back('{1'b1, 8'h02, 32'h3C,       32'h0,        "w_master"});
    rv.push_back('{1'b0, 8'h02, 32'h0,        32'h3C,       "master_rw"});
    rv.push_back('{1'b1, 8'h02, 32'h1FF,      32'h0,        "w_master_wide"});
    rv.push_back('{1'b0, 8'h02, 32'h0,        32'hFF,       "master_trunc"});
    rv.push_back('{1'b0, 8'h12, 32'h0,        32'h80,       "ch0_vol_reset"});
    rv.push_back('{1'b0, 8'h2E, 32'h0,        32'h80,       "ch7_vol_reset"});
    rv.push_back('{1'b1, 8'h12, 32'h11,       32'h0,        "w_ch0_vol"});
    rv.push_back('{1'b0, 8'h12, 32'h0,        32'h11,       "ch0_vol_rw"});
    rv.push_back('{1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        "w_ch0_addr"});
    rv.push_back('{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, "ch0_addr_rw"});
    rv.push_back('{1'b1, 8'h2C, 32'hCAFE0000, 32'h0,        "w_ch7_addr"});
    rv.push_back('{1'b0, 8'h2C, 32'h0,        32'hCAFE0000, "ch7_addr_rw"});
    rv.push_back('{1'b1, 8'h13, 32'h77,       32'h0,        "w_reserved"});
    rv.push_back('{1'b0, 8'h13, 32'h0,        32'h0,        "reserved_zero"});
    rv.push_back('{1'b1, 8'h01, 32'hFF,       32'h0,        "w_busy_ro"});
    rv.push_back('{1'b0, 8'h01, 32'h0,        32'h0,        "busy_ro"});
    rv.push_back('{1'b0, 8'h03, 32'h0,        32'h0,        "done_reset"});
    rv.push_back('{1'b0, 8'h0F, 32'h0,        32'h0,        "unmapped_0f"});
    rv.push_back('{1'b1, 8'h30, 32'h1234,     32'h0,        "w_ch8"});
    rv.push_back('{1'b0, 8'h30, 32'h0,        32'h0,        "ch8_absent"});
    rv.push_back('{1'b0, 8'hFE, 32'h0,        32'h0,        "unmapped_fe"});
    rv.push_back('{1'b1, 8'h04, 32'h5,        32'h0,        "w_irq_en"});
    rv.push_back('{1'b0, 8'h04, 32'h0,        exp_irq_reg,  "irq_en_reg"});

    // ch0 sample = {right 0x2000, left 0x4000}
    mv.push_back('{8'h40, 8'h80, 16'h2000, 16'h1000});
    mv.push_back('{8'h00, 8'h80, 16'h0000, 16'h0000});
    mv.push_back('{8'hFF, 8'h80, 16'h7F80, 16'h3FC0});
    mv.push_back('{8'h80, 8'h40, 16'h2000, 16'h1000});
    mv.push_back('{8'hFF, 8'hFF, 16'h7FFF, 16'h7F00});
    mv.push_back('{8'h80, 8'h00, 16'h0000, 16'h0000});

    // Reset values
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_dma_req", 32'(o_dma_request), 32'd0);
    check("rst_dma_addr", o_dma_address, 32'd0);
    check("rst_rate", o_output_sample_rate, 32'd17);
    check("rst_left", 32'(o_output_sample_left), 32'd0);
    check("rst_right", 32'(o_output_sample_right), 32'd0);

    // Handshake timing
    i_request = 1'b1; i_rw = 1'b0; i_address = 8'h00;
    @(negedge clk);
    check("hs_ready_rise", 32'(o_ready), 32'd1);
    check("hs_rdata_rate", o_rdata, 32'd17);
    @(negedge clk);
    check("hs_ready_hold", 32'(o_ready), 32'd1);
    i_request = 1'b0;
    @(negedge clk);
    check("hs_ready_fall", 32'(o_ready), 32'd0);
    cpu_read(8'h01, rd);
    check("busy_reset", rd, 32'd0);

    foreach (rv[i]) begin
      cpu_xfer(rv[i].rw, rv[i].addr, rv[i].data, rd);
      if (!rv[i].rw) check(rv[i].name, rd, rv[i].exp);
    end

    // Round-robin: channels 0 and 2, four words each
    do_reset();
    i_output_sample_clock = 1'b1;
    cpu_write(8'h10, 32'h1000);
    cpu_write(8'h18, 32'h2000);
    cpu_write(8'h11, 32'd4);
    cpu_write(8'h19, 32'd4);
    for (int g = 0; g < 8; g++) begin
      serve_dma(32'h0, a);
      check($sformatf("grant_%0d_addr", g), a,
            ((g % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(4 * (g / 2)));
    end
    repeat (4) @(negedge clk);
    check("rr_idle_req", 32'(o_dma_request), 32'd0);
    cpu_read(8'h01, rd);
    check("rr_busy_clear", rd, 32'd0);
    cpu_read(8'h03, rd);
    check("rr_done_0_2", rd, 32'h5);

    // Mixer latency, then volume table
    do_reset();
    i_output_sample_clock = 1'b1;
    cpu_write(8'h11, 32'd1);
    serve_dma(32'h2000_4000, a);
    repeat (3) @(negedge clk);
    check("lat_before_left", 32'(o_output_sample_left), 32'd0);
    @(negedge clk);
    check("lat_left", 32'(o_output_sample_left), 32'h4000);
    check("lat_right", 32'(o_output_sample_right), 32'h2000);
    foreach (mv[i]) begin
      cpu_write(8'h12, 32'(mv[i].vol));
      cpu_write(8'h02, 32'(mv[i].mvol));
      repeat (4) @(negedge clk);
      check($sformatf("mix_%0d_left", i), 32'(o_output_sample_left), 32'(mv[i].exp_l));
      check($sformatf("mix_%0d_right", i), 32'(o_output_sample_right), 32'(mv[i].exp_r));
    end

    // Negative samples: arithmetic shift floors toward -inf
    do_reset();
    i_output_sample_clock = 1'b1;
    cpu_write(8'h12, 32'h40);
    cpu_write(8'h11, 32'd1);
    serve_dma(32'hFFFF_C000, a);
    repeat (6) @(negedge clk);
    check("neg_left", 32'(o_output_sample_left), 32'hE000);
    check("neg_right_floor", 32'(o_output_sample_right), 32'hFFFF);

    // Saturation: four channels at +0x7000 left, -0x7000 right
    do_reset();
    i_output_sample_clock = 1'b1;
    cpu_write(8'h11, 32'd1);
    cpu_write(8'h15, 32'd1);
    cpu_write(8'h19, 32'd1);
    cpu_write(8'h1D, 32'd1);
    for (int g = 0; g < 4; g++) serve_dma(32'h9000_7000, a);
    repeat (6) @(negedge clk);
    check("sat_pos", 32'(o_output_sample_left), 32'h7FFF);
    check("sat_neg", 32'(o_output_sample_right), 32'h8000);

    // Done flags and W1C race
    do_reset();
    i_output_sample_clock = 1'b1;
    cpu_write(8'h15, 32'd1);
    serve_dma(32'h0, a);
    repeat (3) @(negedge clk);
    cpu_read(8'h03, rd);
    check("done_ch1", rd, 32'h2);
    cpu_write(8'h03, 32'h2);
    cpu_read(8'h03, rd);
    check("done_w1c", rd, 32'h0);
    i_output_sample_clock = 1'b0;
    cpu_write(8'h15, 32'd1);
    serve_dma(32'h0, a);
    repeat (2) @(negedge clk);
    cpu_read(8'h01, rd);
    check("busy_ch1", rd, 32'h2);
    i_output_sample_clock = 1'b1;
    @(negedge clk);
    i_output_sample_clock = 1'b0;
    cpu_write(8'h03, 32'h2);
    cpu_read(8'h03, rd);
    check("done_set_wins", rd, 32'h2);

`ifdef AUDIO_MIXER_IRQ_EN
    do_reset();
    check("irq_reset", 32'(o_interrupt), 32'd0);
    cpu_write(8'h04, 32'h1);
    i_output_sample_clock = 1'b1;
    cpu_write(8'h11, 32'd1);
    serve_dma(32'h0, a);
    repeat (4) @(negedge clk);
    check("irq_set", 32'(o_interrupt), 32'd1);
    i_request = 1'b1; i_rw = 1'b1; i_address = 8'h03; i_wdata = 32'h1;
    @(negedge clk);
    check("irq_hold_after_w1c", 32'(o_interrupt), 32'd1);
    @(negedge clk);
    check("irq_clear", 32'(o_interrupt), 32'd0);
    i_request = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Reset in the middle of a DMA wait
    do_reset();
    cpu_write(8'h10, 32'h3000);
    cpu_write(8'h11, 32'd2);
    wait_dma_req();
    check("wait_addr", o_dma_address, 32'h3000);
    i_reset = 1'b1;
    @(negedge clk);
    check("rst_wait_req", 32'(o_dma_request), 32'd0);
    check("rst_wait_addr", o_dma_address, 32'd0);
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wait_stays_idle", 32'(o_dma_request), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
